eng_cmd_issue: RTL and testbench
================================

ENG_CMD_ISSUE -- requirements
Module: eng_cmd_issue

Interface
REQ-001 SHALL have parameter TAG_N, default 4, number of outstanding-command slots (power of two, >=2).
REQ-002 SHALL have parameter QID_W, default 3, queue-identifier width.
REQ-003 SHALL have parameter DATA_W, default 32, payload width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 arst_n  in  1  asynchronous, active-low reset.
REQ-006 host_cmd_vld / host_cmd_rdy  in / out  1 / 1  host command handshake.
REQ-007 host_cmd_op  in  1  0=push, 1=pop.
REQ-008 host_cmd_qid  in  QID_W  target queue.
REQ-009 host_cmd_dat  in  DATA_W  push payload; ignored for pop.
REQ-010 eng_cmd_vld / eng_cmd_rdy  out / in  1 / 1  engine command handshake.
REQ-011 eng_cmd_op, eng_cmd_qid, eng_cmd_dat  out  1, QID_W, DATA_W  forwarded command fields.
REQ-012 eng_cmd_tag  out  log2(TAG_N)  slot tag of issued command.
REQ-013 eng_rsp_vld  in  1  engine response strobe; no backpressure.
REQ-014 eng_rsp_tag  in  log2(TAG_N)  tag being completed.
REQ-015 eng_rsp_dat, eng_rsp_err  in  DATA_W, 1  pop data; error (pop of empty queue / push to full).
REQ-016 host_rsp_vld / host_rsp_rdy  out / in  1 / 1  host response handshake.
REQ-017 host_rsp_op, host_rsp_dat, host_rsp_err  out  1, DATA_W, 1  in-order completion.
REQ-018 busy  out  1  high while any slot is allocated.
REQ-019 proto_err  out  1  sticky: response received for a tag not awaiting completion.

Function
REQ-020 Slots SHALL form a ring: alloc pointer (ap), retire pointer (rp), occupancy count (cnt, 0..TAG_N).
REQ-021 host_cmd_rdy SHALL equal eng_cmd_rdy AND (cnt < TAG_N); purely combinational pass-through, zero latency.
REQ-022 eng_cmd_vld SHALL equal host_cmd_vld AND (cnt < TAG_N); eng_cmd_op/qid/dat SHALL equal host fields; eng_cmd_tag SHALL equal ap.
REQ-023 On issue (eng_cmd_vld & eng_cmd_rdy): slot[ap] state PEND, op recorded, ap increments modulo TAG_N.
REQ-024 Per-slot states: FREE -> PEND (issue) -> DONE (response) -> FREE (retire); no other transitions.
REQ-025 On eng_rsp_vld with slot[eng_rsp_tag]==PEND: capture dat/err, state DONE, next cycle.
REQ-026 On eng_rsp_vld with slot state FREE or DONE: slot unchanged, proto_err set to 1 until reset.
REQ-027 host_rsp_vld SHALL be 1 exactly when slot[rp]==DONE; fields driven from slot[rp] (registered storage, combinational select).
REQ-028 On host_rsp_vld & host_rsp_rdy: slot[rp] FREE, rp increments modulo TAG_N.
REQ-029 Responses SHALL retire strictly in issue order regardless of engine completion order.
REQ-030 cnt SHALL increment on issue, decrement on retire, unchanged when both occur same cycle.
REQ-031 Full (cnt==TAG_N): no issue; a same-cycle retire does not enable issue until next cycle.
REQ-032 Response to tag rp in same cycle rp becomes DONE: host_rsp_vld rises next cycle (one-cycle minimum rsp-to-host latency).
REQ-033 Issue and response to a different slot in same cycle SHALL both take effect.
REQ-034 busy SHALL equal (cnt != 0).

Reset
REQ-035 While arst_n low: ap=0, rp=0, cnt=0, all slots FREE, proto_err=0, host_rsp_vld=0, busy=0, eng_cmd_vld=host_cmd_vld & 1.
REQ-036 Reset asserted mid-operation SHALL discard all outstanding slots; responses arriving after release for pre-reset tags set proto_err.
REQ-037 Captured slot data/op SHALL NOT require reset.

Verification
REQ-038 Reset, single push qid=2 dat=0xA5A5_0001, eng responds tag 0 err=0 -> host_rsp_vld one cycle later, op=0, err=0; busy falls after retire.
REQ-039 TAG_N=4: issue 4 pops, hold eng_rsp_vld low -> host_cmd_rdy=0 on 5th, cnt=4, busy=1.
REQ-040 Issue tags 0,1,2; respond 2,0,1 with dat 0x22,0x00,0x11 -> host sees 0x00,0x11,0x22 in that order.
REQ-041 host_rsp_rdy=0 with slot 0 DONE, then full ring -> no issue until host_rsp_rdy=1; ap/rp wrap 3->0 correctly over 10 commands.
REQ-042 eng_rsp_vld with tag 3 while slot 3 FREE -> proto_err=1, persists, cleared only by arst_n.
REQ-043 Assert arst_n low with 3 slots PEND -> cnt=0, busy=0, host_rsp_vld=0 immediately (asynchronous).

Source files
------------

// File: rtl/eng_cmd_issue.sv
// eng_cmd_issue: tagged command issue ring with out-of-order completion and in-order host retirement
module eng_cmd_issue #(
    parameter int TAG_N  = 4,
    parameter int QID_W  = 3,
    parameter int DATA_W = 32,
    localparam int TW    = $clog2(TAG_N)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              host_cmd_vld,
    output logic              host_cmd_rdy,
    input  logic              host_cmd_op,
    input  logic [QID_W-1:0]  host_cmd_qid,
    input  logic [DATA_W-1:0] host_cmd_dat,
    output logic              eng_cmd_vld,
    input  logic              eng_cmd_rdy,
    output logic              eng_cmd_op,
    output logic [QID_W-1:0]  eng_cmd_qid,
    output logic [DATA_W-1:0] eng_cmd_dat,
    output logic [TW-1:0]     eng_cmd_tag,
    input  logic              eng_rsp_vld,
    input  logic [TW-1:0]     eng_rsp_tag,
    input  logic [DATA_W-1:0] eng_rsp_dat,
    input  logic              eng_rsp_err,
    output logic              host_rsp_vld,
    input  logic              host_rsp_rdy,
    output logic              host_rsp_op,
    output logic [DATA_W-1:0] host_rsp_dat,
    output logic              host_rsp_err,
    output logic              busy,
    output logic              proto_err
);
    typedef enum logic [1:0] {FREE, PEND, DONE} slot_e;
    localparam int CW = TW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(TAG_N);

    slot_e             st_q  [TAG_N];
    slot_e             st_d  [TAG_N];
    logic              op_q  [TAG_N];
    logic              op_d  [TAG_N];
    logic              err_q [TAG_N];
    logic              err_d [TAG_N];
    logic [DATA_W-1:0] dat_q [TAG_N];
    logic [DATA_W-1:0] dat_d [TAG_N];
    logic [TW-1:0]     ap_q, ap_d, rp_q, rp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              proto_err_q, proto_err_d;
    logic              not_full, issue, retire;

    assign not_full     = cnt_q != CNT_FULL;
    assign host_cmd_rdy = eng_cmd_rdy & not_full;
    assign eng_cmd_vld  = host_cmd_vld & not_full;
    assign eng_cmd_op   = host_cmd_op;
    assign eng_cmd_qid  = host_cmd_qid;
    assign eng_cmd_dat  = host_cmd_dat;
    assign eng_cmd_tag  = ap_q;
    assign issue        = eng_cmd_vld & eng_cmd_rdy;
    assign host_rsp_vld = st_q[rp_q] == DONE;
    assign host_rsp_op  = op_q[rp_q];
    assign host_rsp_dat = dat_q[rp_q];
    assign host_rsp_err = err_q[rp_q];
    assign retire       = host_rsp_vld & host_rsp_rdy;
    assign busy         = cnt_q != '0;
    assign proto_err    = proto_err_q;

    // Issued slot is always FREE and retired slot always DONE, so the three
    // slot updates below can never target the same entry in one cycle.
    always_comb begin
        st_d        = st_q;
        op_d        = op_q;
        dat_d       = dat_q;
        err_d       = err_q;
        ap_d        = issue ? ap_q + TW'(1) : ap_q;
        rp_d        = retire ? rp_q + TW'(1) : rp_q;
        cnt_d       = cnt_q + CW'(issue) - CW'(retire);
        proto_err_d = proto_err_q | (eng_rsp_vld & (st_q[eng_rsp_tag] != PEND));
        if (issue) begin
            st_d[ap_q] = PEND;
            op_d[ap_q] = host_cmd_op;
        end
        if (eng_rsp_vld && st_q[eng_rsp_tag] == PEND) begin
            st_d[eng_rsp_tag]  = DONE;
            dat_d[eng_rsp_tag] = eng_rsp_dat;
            err_d[eng_rsp_tag] = eng_rsp_err;
        end
        if (retire) st_d[rp_q] = FREE;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            st_q        <= '{default: FREE};
            ap_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            ap_q        <= ap_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q  <= op_d;
        dat_q <= dat_d;
        err_q <= err_d;
    end
endmodule

// File: tb/tb_eng_cmd_issue.sv
// tb_eng_cmd_issue: directed + randomized check of eng_cmd_issue against an in-order queue model
module tb_eng_cmd_issue;
    localparam int TAG_N  = 4;
    localparam int QID_W  = 3;
    localparam int DATA_W = 32;
    localparam int TW     = $clog2(TAG_N);

    logic              clk = 1'b0;
    logic              arst_n = 1'b1;
    logic              host_cmd_vld = 1'b0, host_cmd_op = 1'b0;
    logic [QID_W-1:0]  host_cmd_qid = '0;
    logic [DATA_W-1:0] host_cmd_dat = '0;
    logic              eng_cmd_rdy = 1'b0;
    logic              eng_rsp_vld = 1'b0, eng_rsp_err = 1'b0;
    logic [TW-1:0]     eng_rsp_tag = '0;
    logic [DATA_W-1:0] eng_rsp_dat = '0;
    logic              host_rsp_rdy = 1'b0;
    logic              host_cmd_rdy, eng_cmd_vld, eng_cmd_op;
    logic [QID_W-1:0]  eng_cmd_qid;
    logic [DATA_W-1:0] eng_cmd_dat;
    logic [TW-1:0]     eng_cmd_tag;
    logic              host_rsp_vld, host_rsp_op, host_rsp_err, busy, proto_err;
    logic [DATA_W-1:0] host_rsp_dat;

    eng_cmd_issue #(.TAG_N(TAG_N), .QID_W(QID_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .arst_n(arst_n),
        .host_cmd_vld(host_cmd_vld), .host_cmd_rdy(host_cmd_rdy), .host_cmd_op(host_cmd_op),
        .host_cmd_qid(host_cmd_qid), .host_cmd_dat(host_cmd_dat),
        .eng_cmd_vld(eng_cmd_vld), .eng_cmd_rdy(eng_cmd_rdy), .eng_cmd_op(eng_cmd_op),
        .eng_cmd_qid(eng_cmd_qid), .eng_cmd_dat(eng_cmd_dat), .eng_cmd_tag(eng_cmd_tag),
        .eng_rsp_vld(eng_rsp_vld), .eng_rsp_tag(eng_rsp_tag), .eng_rsp_dat(eng_rsp_dat),
        .eng_rsp_err(eng_rsp_err),
        .host_rsp_vld(host_rsp_vld), .host_rsp_rdy(host_rsp_rdy), .host_rsp_op(host_rsp_op),
        .host_rsp_dat(host_rsp_dat), .host_rsp_err(host_rsp_err),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding commands in issue order.
    typedef struct {
        int              tag;
        logic            op;
        bit              done;
        logic [DATA_W-1:0] dat;
        logic            err;
    } ent_t;
    ent_t q[$];
    int   next_tag = 0;
    bit   m_perr   = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input bit hv, input bit hop, input logic [QID_W-1:0] qid,
                       input logic [DATA_W-1:0] hd, input bit erdy, input bit rv,
                       input logic [TW-1:0] rt, input logic [DATA_W-1:0] rd,
                       input bit re, input bit hr);
        bit full, hvld, iss, ret, hit;
        @(negedge clk);
        host_cmd_vld = hv; host_cmd_op = hop; host_cmd_qid = qid; host_cmd_dat = hd;
        eng_cmd_rdy = erdy; eng_rsp_vld = rv; eng_rsp_tag = rt; eng_rsp_dat = rd;
        eng_rsp_err = re; host_rsp_rdy = hr;
        #1;
        full = q.size() >= TAG_N;
        hvld = q.size() > 0 && q[0].done;
        chk("host_cmd_rdy", host_cmd_rdy, erdy && !full);
        chk("eng_cmd_vld", eng_cmd_vld, hv && !full);
        chk("eng_cmd_tag", eng_cmd_tag, next_tag);
        chk("eng_cmd_op", eng_cmd_op, hop);
        chk("eng_cmd_qid", eng_cmd_qid, qid);
        chk("eng_cmd_dat", eng_cmd_dat, hd);
        chk("host_rsp_vld", host_rsp_vld, hvld);
        if (hvld) begin
            chk("host_rsp_op", host_rsp_op, q[0].op);
            chk("host_rsp_dat", host_rsp_dat, q[0].dat);
            chk("host_rsp_err", host_rsp_err, q[0].err);
        end
        chk("busy", busy, q.size() != 0);
        chk("proto_err", proto_err, m_perr);
        @(posedge clk);
        iss = hv && erdy && !full;
        ret = hvld && hr;
        if (rv) begin
            hit = 0;
            foreach (q[i])
                if (!hit && q[i].tag == int'(rt) && !q[i].done) begin
                    q[i].done = 1; q[i].dat = rd; q[i].err = re; hit = 1;
                end
            if (!hit) m_perr = 1;
        end
        if (ret) void'(q.pop_front());
        if (iss) begin
            q.push_back('{tag: next_tag, op: hop, done: 0, dat: '0, err: 0});
            next_tag = (next_tag + 1) % TAG_N;
        end
    endtask

    task automatic idle(input bit hr);
        cyc(0, 0, '0, '0, 1, 0, '0, '0, 0, hr);
    endtask

    task automatic rsp(input int t, input logic [DATA_W-1:0] d, input bit e, input bit hr);
        cyc(0, 0, '0, '0, 1, 1, TW'(t), d, e, hr);
    endtask

    task automatic do_reset();
        #2 arst_n = 1'b0;
        host_cmd_vld = 1'b1; eng_cmd_rdy = 1'b1; eng_rsp_vld = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_host_rsp_vld", host_rsp_vld, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_eng_cmd_vld", eng_cmd_vld, host_cmd_vld);
        chk("rst_host_cmd_rdy", host_cmd_rdy, 1);
        q.delete(); next_tag = 0; m_perr = 0;
        host_cmd_vld = 1'b0; host_rsp_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) arst_n = 1'b1;
    endtask

    initial begin
        int pend[$];
        do_reset();
        // single push, out-of-band response, one-cycle host latency
        cyc(1, 0, 3'd2, 32'hA5A5_0001, 1, 0, '0, '0, 0, 0);
        rsp(0, 32'h1234_5678, 0, 0);
        #1 chk("single_vld", host_rsp_vld, 1);
        chk("single_op", host_rsp_op, 0);
        chk("single_err", host_rsp_err, 0);
        chk("single_busy", busy, 1);
        idle(1);
        #1 chk("single_busy_after", busy, 0);
        // full ring of pops with engine silent
        do_reset();
        repeat (4) cyc(1, 1, 3'd1, '0, 1, 0, '0, '0, 0, 0);
        #1 chk("full_rdy", host_cmd_rdy, 0);
        chk("full_busy", busy, 1);
        cyc(1, 1, 3'd1, '0, 1, 0, '0, '0, 0, 0);
        // host stalls with slot 0 done; retire while full does not issue same cycle
        rsp(0, 32'hD0, 1, 0);
        repeat (3) cyc(1, 1, 3'd5, 32'h55, 1, 0, '0, '0, 0, 0);
        #1 chk("stall_vld", host_rsp_vld, 1);
        chk("stall_rdy", host_cmd_rdy, 0);
        cyc(1, 1, 3'd5, 32'h55, 1, 0, '0, '0, 0, 1);
        cyc(1, 1, 3'd5, 32'h66, 1, 0, '0, '0, 0, 0);
        // out-of-order completion, in-order retirement
        do_reset();
        repeat (3) cyc(1, 1, 3'd3, '0, 1, 0, '0, '0, 0, 0);
        rsp(2, 32'h22, 0, 0);
        rsp(0, 32'h00, 0, 0);
        rsp(1, 32'h11, 0, 0);
        #1 chk("ooo_0", host_rsp_dat, 32'h00);
        idle(1);
        #1 chk("ooo_1", host_rsp_dat, 32'h11);
        idle(1);
        #1 chk("ooo_2", host_rsp_dat, 32'h22);
        idle(1);
        #1 chk("ooo_empty", busy, 0);
        // ten commands wrapping the ring
        for (int k = 0; k < 10; k++) begin
            cyc(1, k[0], QID_W'(k), DATA_W'(k * 7), 1, 0, '0, '0, 0, 1);
            rsp(k % TAG_N, DATA_W'(k + 100), k[1], 1);
        end
        repeat (2) idle(1);
        // response to a free slot is a sticky protocol error
        do_reset();
        rsp(3, 32'hBAD, 0, 0);
        #1 chk("perr_set", proto_err, 1);
        repeat (3) idle(1);
        #1 chk("perr_hold", proto_err, 1);
        // asynchronous reset with three outstanding, then stale response
        do_reset();
        repeat (3) cyc(1, 0, 3'd4, 32'h77, 1, 0, '0, '0, 0, 0);
        do_reset();
        rsp(1, 32'h1, 0, 0);
        #1 chk("stale_perr", proto_err, 1);
        // randomized traffic with well-formed responses
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            pend = {};
            foreach (q[i]) if (!q[i].done) pend.push_back(q[i].tag);
            cyc($urandom % 4 != 0, $urandom % 2, QID_W'($urandom), $urandom, $urandom % 4 != 0,
                pend.size() > 0 && $urandom % 2 == 1,
                pend.size() > 0 ? TW'(pend[$urandom_range(pend.size() - 1)]) : TW'(0),
                $urandom, $urandom % 5 == 0, $urandom % 3 != 0);
        end
        // randomized traffic including stray responses
        for (int n = 0; n < 300; n++)
            cyc($urandom % 2, $urandom % 2, QID_W'($urandom), $urandom, $urandom % 2,
                $urandom % 3 == 0, TW'($urandom), $urandom, $urandom % 2, $urandom % 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
